// File: rtl/sat_narrow.sv
// Narrowing stage: range-checks a DATA_WIDTH signed word, then passes it through, saturates or wraps
// it into OPERAND_WIDTH bits. Results are queued in a 2-entry buffer; overflows are tracked per word,
// by a sticky flag and by a saturating counter.
module sat_narrow #(
  parameter int DATA_WIDTH    = 16,
  parameter int OPERAND_WIDTH = 11,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_sat_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPERAND_WIDTH-1:0] out_data,
  output logic                     out_ovf,
  input  logic                     ovf_clr,
  output logic                     ovf_sticky,
  output logic [CNT_WIDTH-1:0]     ovf_count
);

  localparam logic [OPERAND_WIDTH-1:0] SAT_POS = {1'b0, {(OPERAND_WIDTH-1){1'b1}}};
  localparam logic [OPERAND_WIDTH-1:0] SAT_NEG = {1'b1, {(OPERAND_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0]     CNT_MAX = '1;

  logic [DATA_WIDTH-OPERAND_WIDTH:0] upper_bits;
  logic                              fits;
  logic [OPERAND_WIDTH-1:0]          nar_data;
  logic                              nar_ovf;

  logic [1:0]               occ_q, occ_d;
  logic                     wr_ptr_q, rd_ptr_q;
  logic [OPERAND_WIDTH-1:0] data_q [2];
  logic                     ovf_q  [2];
  logic                     sticky_q;
  logic [CNT_WIDTH-1:0]     count_q;

  logic accept, xfer, accept_ovf;

  // The word fits when the sign bit of the narrow field matches every bit dropped above it.
  assign upper_bits = in_data[DATA_WIDTH-1:OPERAND_WIDTH-1];
  assign fits       = (&upper_bits) | ~(|upper_bits);

  // NOTE: every variable written in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    nar_data = in_data[OPERAND_WIDTH-1:0];
    nar_ovf  = ~fits;
    if (!fits && in_sat_en) begin
      nar_data = in_data[DATA_WIDTH-1] ? SAT_NEG : SAT_POS;
    end
  end

  assign in_ready   = (occ_q != 2'd2);
  assign out_valid  = (occ_q != 2'd0);
  assign accept     = in_valid & in_ready;
  assign xfer       = out_valid & out_ready;
  assign accept_ovf = accept & nar_ovf;

  always_comb begin
    occ_d = occ_q;
    case ({accept, xfer})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      if (accept) wr_ptr_q <= ~wr_ptr_q;
      if (xfer)   rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // NOTE: buffer entries are reset because the head entry is visible on out_data and must read 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        ovf_q[i]  <= 1'b0;
      end
    end else if (accept) begin
      data_q[wr_ptr_q] <= nar_data;
      ovf_q[wr_ptr_q]  <= nar_ovf;
    end
  end

  // A new overflow beats a clear on the same edge; the counter then restarts from 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else if (accept_ovf) begin
      sticky_q <= 1'b1;
      if (ovf_clr)                   count_q <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      else if (count_q != CNT_MAX)   count_q <= count_q + 1'b1;
    end else if (ovf_clr) begin
      sticky_q <= 1'b0;
      count_q  <= '0;
    end
  end

  assign out_data   = data_q[rd_ptr_q];
  assign out_ovf    = ovf_q[rd_ptr_q];
  assign ovf_sticky = sticky_q;
  assign ovf_count  = count_q;

endmodule
